// File: rtl/calc_pkg.sv
// Shared definitions for the matrix printer: dimension limits, ASCII codes,
// printer state encoding and small arithmetic helpers.
package calc_pkg;

  localparam int MAX_DIM = 5;
  localparam int RD_LAT  = 1;

  // Row/column counters only ever need to hold 0..MAX_DIM.
  localparam int DIM_W = 3;

  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_INIT     = 4'd1,
    ST_FETCH    = 4'd2,
    ST_WAIT     = 4'd3,
    ST_CONV     = 4'd4,
    ST_EMIT_DIG = 4'd5,
    ST_EMIT_SEP = 4'd6,
    ST_EMIT_CR  = 4'd7,
    ST_EMIT_LF  = 4'd8,
    ST_DONE     = 4'd9
  } prt_state_e;

  // Row-major element offset; all operands are tiny so 8 bits never overflow.
  function automatic logic [7:0] elem_index(input logic [DIM_W-1:0] row,
                                            input logic [DIM_W-1:0] col,
                                            input logic [DIM_W-1:0] n);
    logic [7:0] r8;
    logic [7:0] c8;
    logic [7:0] n8;
    r8 = {5'd0, row};
    c8 = {5'd0, col};
    n8 = {5'd0, n};
    return (r8 * n8) + c8;
  endfunction

  // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
  function automatic logic [39:0] dabble_adjust(input logic [39:0] bcd);
    logic [39:0] res;
    res = bcd;
    for (int i = 0; i < 10; i++) begin
      if (res[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = res[i*4 +: 4] + 4'd3;
      end else begin
        res[i*4 +: 4] = res[i*4 +: 4];
      end
    end
    return res;
  endfunction

  // Index of the most significant non-zero digit; 0 when the value is zero,
  // so a zero value still prints a single "0".
  function automatic logic [3:0] msd_index(input logic [39:0] bcd);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (bcd[i*4 +: 4] != 4'd0) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // ASCII character of BCD digit number idx (0 = units).
  function automatic logic [7:0] digit_ascii(input logic [39:0] bcd, input logic [3:0] idx);
    logic [3:0] d;
    d = bcd[{idx, 2'b00} +: 4];
    return ASCII_ZERO + {4'd0, d};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit binary to 10-digit BCD converter (double-dabble, one
// bit per cycle). A start pulse while idle launches a conversion; 32 shift
// cycles later plus one output cycle, done pulses and bcd_out holds the result
// until the next conversion completes.
module bin2bcd_seq
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] bin_in,
  output logic        done,
  output logic [39:0] bcd_out
);

  logic [31:0] bin_q, bin_d;
  logic [39:0] bcd_q, bcd_d;
  logic [39:0] out_q, out_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic        done_q, done_d;
  logic [39:0] adj_s;

  // Next-state: load on start, shift 32 times, then publish the result.
  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    out_d  = out_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    adj_s  = dabble_adjust(bcd_q);
    if (run_q) begin
      if (cnt_q == 6'd32) begin
        run_d  = 1'b0;
        done_d = 1'b1;
        out_d  = bcd_q;
      end else begin
        bcd_d = {adj_s[38:0], bin_q[31]};
        bin_d = {bin_q[30:0], 1'b0};
        cnt_d = cnt_q + 6'd1;
      end
    end else if (start) begin
      bin_d = bin_in;
      bcd_d = 40'd0;
      cnt_d = 6'd0;
      run_d = 1'b1;
    end else begin
      run_d = 1'b0;
    end
  end

  // Converter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= 32'd0;
      bcd_q  <= 40'd0;
      out_q  <= 40'd0;
      cnt_q  <= 6'd0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done    = done_q;
  assign bcd_out = out_q;

endmodule

// File: rtl/matrix_result_printer.sv
// Reads a row-major result matrix back from storage and streams it as ASCII
// decimal text over a valid/ready byte interface: elements separated by a
// space, each row terminated by CR LF.
// Optional feature macro PRINT_SIGNED_EN: treat elements as two's complement
// and prefix negative values with '-'. Without it, values print unsigned.
module matrix_result_printer #(
  parameter int MAX_DIM = calc_pkg::MAX_DIM,
  parameter int RD_LAT  = calc_pkg::RD_LAT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start_print,
  input  logic [7:0]  i_base_addr,
  input  logic [31:0] i_m,
  input  logic [31:0] i_n,
  output logic        o_busy,
  output logic        o_print_done,
  output logic        o_err,
  output logic [7:0]  o_rd_addr,
  input  logic [31:0] i_rd_data,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready
);

  import calc_pkg::*;

  prt_state_e       state_q, state_d;
  logic [7:0]       base_q, base_d;
  logic [DIM_W-1:0] m_q, m_d;
  logic [DIM_W-1:0] n_q, n_d;
  logic [DIM_W-1:0] row_q, row_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic             err_flag_q, err_flag_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic [31:0]      value_q, value_d;
  logic             bcd_start_q, bcd_start_d;
  logic [3:0]       dig_idx_q, dig_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [7:0]       rd_addr_q, rd_addr_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
`ifdef PRINT_SIGNED_EN
  logic             neg_q, neg_d;
`endif

  logic        bcd_done_s;
  logic [39:0] bcd_s;
  logic        hs_s;
  logic        dims_bad_s;
  logic        sign_pend_s;
  logic [3:0]  msd_s;

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (bcd_start_q),
    .bin_in  (value_q),
    .done    (bcd_done_s),
    .bcd_out (bcd_s)
  );

  // Printer sequencing: computes every next-state value from current state.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    m_d         = m_q;
    n_d         = n_q;
    row_d       = row_q;
    col_d       = col_q;
    err_flag_d  = err_flag_q;
    wait_cnt_d  = wait_cnt_q;
    value_d     = value_q;
    bcd_start_d = 1'b0;
    dig_idx_d   = dig_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rd_addr_d   = rd_addr_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
`ifdef PRINT_SIGNED_EN
    neg_d       = neg_q;
    sign_pend_s = neg_q;
`else
    sign_pend_s = 1'b0;
`endif
    hs_s        = tx_valid_q & i_tx_ready;
    msd_s       = msd_index(bcd_s);
    dims_bad_s  = (i_m == 32'd0) || (i_n == 32'd0) ||
                  (i_m > 32'(MAX_DIM)) || (i_n > 32'(MAX_DIM));

    case (state_q)
      ST_IDLE: begin
        if (i_start_print) begin
          busy_d     = 1'b1;
          err_flag_d = 1'b0;
          state_d    = ST_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_INIT: begin
        base_d = i_base_addr;
        if (dims_bad_s) begin
          err_flag_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          m_d     = i_m[DIM_W-1:0];
          n_d     = i_n[DIM_W-1:0];
          row_d   = '0;
          col_d   = '0;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        // Address arithmetic wraps in 8 bits by construction.
        rd_addr_d  = base_q + elem_index(row_q, col_q, n_q);
        wait_cnt_d = 4'd0;
        state_d    = ST_WAIT;
      end

      ST_WAIT: begin
        if (wait_cnt_q == 4'(RD_LAT)) begin
`ifdef PRINT_SIGNED_EN
          neg_d   = i_rd_data[31];
          value_d = i_rd_data[31] ? (~i_rd_data + 32'd1) : i_rd_data;
`else
          value_d = i_rd_data;
`endif
          bcd_start_d = 1'b1;
          state_d     = ST_CONV;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end

      ST_CONV: begin
        if (bcd_done_s) begin
          dig_idx_d  = msd_s;
          tx_valid_d = 1'b1;
          tx_data_d  = sign_pend_s ? ASCII_MINUS : digit_ascii(bcd_s, msd_s);
          state_d    = ST_EMIT_DIG;
        end else begin
          state_d = ST_CONV;
        end
      end

      ST_EMIT_DIG: begin
        // Next byte is loaded on the accepting edge so digits flow back-to-back.
        if (hs_s) begin
          if (sign_pend_s) begin
`ifdef PRINT_SIGNED_EN
            neg_d = 1'b0;
`endif
            tx_data_d = digit_ascii(bcd_s, dig_idx_q);
          end else if (dig_idx_q != 4'd0) begin
            dig_idx_d = dig_idx_q - 4'd1;
            tx_data_d = digit_ascii(bcd_s, dig_idx_q - 4'd1);
          end else if (col_q != (n_q - 3'd1)) begin
            tx_data_d = ASCII_SP;
            state_d   = ST_EMIT_SEP;
          end else begin
            tx_data_d = ASCII_CR;
            state_d   = ST_EMIT_CR;
          end
        end else begin
          state_d = ST_EMIT_DIG;
        end
      end

      ST_EMIT_SEP: begin
        if (hs_s) begin
          tx_valid_d = 1'b0;
          col_d      = col_q + 3'd1;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_EMIT_SEP;
        end
      end

      ST_EMIT_CR: begin
        if (hs_s) begin
          tx_data_d = ASCII_LF;
          state_d   = ST_EMIT_LF;
        end else begin
          state_d = ST_EMIT_CR;
        end
      end

      ST_EMIT_LF: begin
        if (hs_s) begin
          tx_valid_d = 1'b0;
          col_d      = '0;
          if (row_q == (m_q - 3'd1)) begin
            state_d = ST_DONE;
          end else begin
            row_d   = row_q + 3'd1;
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_EMIT_LF;
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        err_d   = err_flag_q;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // All printer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      base_q      <= 8'd0;
      m_q         <= '0;
      n_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      err_flag_q  <= 1'b0;
      wait_cnt_q  <= 4'd0;
      value_q     <= 32'd0;
      bcd_start_q <= 1'b0;
      dig_idx_q   <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_addr_q   <= 8'd0;
      tx_data_q   <= 8'd0;
      tx_valid_q  <= 1'b0;
`ifdef PRINT_SIGNED_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      m_q         <= m_d;
      n_q         <= n_d;
      row_q       <= row_d;
      col_q       <= col_d;
      err_flag_q  <= err_flag_d;
      wait_cnt_q  <= wait_cnt_d;
      value_q     <= value_d;
      bcd_start_q <= bcd_start_d;
      dig_idx_q   <= dig_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_addr_q   <= rd_addr_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
`ifdef PRINT_SIGNED_EN
      neg_q       <= neg_d;
`endif
    end
  end

  assign o_busy       = busy_q;
  assign o_print_done = done_q;
  assign o_err        = err_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_tx_data    = tx_data_q;
  assign o_tx_valid   = tx_valid_q;

endmodule

// File: tb/tb_matrix_result_printer.sv
// Self-checking bench for matrix_result_printer. Expected text is produced
// from the storage contents with $sformatf decimal formatting.
module tb_matrix_result_printer;

  logic        clk;
  logic        rst_n;
  logic        i_start_print;
  logic [7:0]  i_base_addr;
  logic [31:0] i_m;
  logic [31:0] i_n;
  logic        o_busy;
  logic        o_print_done;
  logic        o_err;
  logic [7:0]  o_rd_addr;
  logic [31:0] i_rd_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;

  logic [31:0] mem [0:255];

  int n_assert;
  int n_fail;

  logic [7:0] got_q[$];
  logic [7:0] ref_q[$];
  int done_cnt, err_cnt, vcount, stall_viol, stalls, bubble_viol, busy_bad, timeout;

  matrix_result_printer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start_print (i_start_print),
    .i_base_addr   (i_base_addr),
    .i_m           (i_m),
    .i_n           (i_n),
    .o_busy        (o_busy),
    .o_print_done  (o_print_done),
    .o_err         (o_err),
    .o_rd_addr     (o_rd_addr),
    .i_rd_data     (i_rd_data),
    .o_tx_data     (o_tx_data),
    .o_tx_valid    (o_tx_valid),
    .i_tx_ready    (i_tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage with one cycle of read latency.
  always @(posedge clk) i_rd_data <= mem[o_rd_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic string num_str(input logic [31:0] v);
`ifdef PRINT_SIGNED_EN
    return $sformatf("%0d", $signed(v));
`else
    return $sformatf("%0d", v);
`endif
  endfunction

  function automatic string exp_text(input logic [7:0] base, input int m, input int n);
    string s;
    logic [7:0] a;
    s = "";
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        a = base + 8'(r * n + c);
        s = {s, num_str(mem[a])};
        if (c < n - 1) s = {s, " "};
      end
      s = {s, "\r\n"};
    end
    return s;
  endfunction

  function automatic bit is_num_char(input logic [7:0] b);
    return ((b >= 8'h30) && (b <= 8'h39)) || (b == 8'h2D);
  endfunction

  // Runs one print, collecting accepted bytes and protocol statistics.
  task automatic run_print(input logic [7:0] base, input logic [31:0] m, input logic [31:0] n,
                           input string exp_s, input bit rnd, input bit restart);
    bit prev_stall;
    bit last_num;
    logic [7:0] prev_data;
    int done_at;
    got_q.delete();
    done_cnt = 0; err_cnt = 0; vcount = 0; stall_viol = 0; stalls = 0;
    bubble_viol = 0; busy_bad = 0; timeout = 1;
    prev_stall = 1'b0; last_num = 1'b0; prev_data = 8'd0; done_at = -1;
    i_base_addr = base; i_m = m; i_n = n;
    @(negedge clk);
    i_start_print = 1'b1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      i_start_print = (restart && cyc == 40);
      if (prev_stall && !(o_tx_valid === 1'b1 && o_tx_data === prev_data)) stall_viol++;
      if (last_num && got_q.size() < exp_s.len() && is_num_char(8'(exp_s[got_q.size()]))
          && o_tx_valid !== 1'b1) bubble_viol++;
      if (o_print_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (o_err === 1'b1) err_cnt++;
      if (o_tx_valid === 1'b1) vcount++;
      if (done_at >= 0 && o_busy !== 1'b0) busy_bad++;
      i_tx_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      prev_stall = o_tx_valid && !i_tx_ready;
      prev_data  = o_tx_data;
      if (prev_stall) stalls++;
      if (o_tx_valid && i_tx_ready) begin
        got_q.push_back(o_tx_data);
        last_num = is_num_char(o_tx_data);
      end else begin
        last_num = 1'b0;
      end
      if (done_at >= 0 && cyc >= done_at + 3) begin
        timeout = 0;
        break;
      end
    end
    i_start_print = 1'b0;
    i_tx_ready = 1'b1;
  endtask

  task automatic cmp_text(input string tag, input string exp_s);
    chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_s.len()));
    for (int i = 0; i < exp_s.len() && i < got_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 64'(got_q[i]), 64'(8'(exp_s[i])));
  endtask

  task automatic chk_run(input string tag, input int exp_err);
    chk({tag, "_timeout"}, 64'(timeout), 64'd0);
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
    chk({tag, "_stall_stable"}, 64'(stall_viol), 64'd0);
    chk({tag, "_bubble"}, 64'(bubble_viol), 64'd0);
    chk({tag, "_busy_after_done"}, 64'(busy_bad), 64'd0);
  endtask

  initial begin
    string s_exp;
    int lat;
    int vseen;
    int errv;
    int waited;
    n_assert = 0; n_fail = 0;
    rst_n = 1'b0; i_start_print = 1'b0; i_base_addr = 8'd0;
    i_m = 32'd0; i_n = 32'd0; i_tx_ready = 1'b1;
    for (int a = 0; a < 256; a++) mem[a] = 32'd0;
    #22;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_print_done), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    chk("rst_valid", 64'(o_tx_valid), 64'd0);
    chk("rst_rd_addr", 64'(o_rd_addr), 64'd0);
    chk("rst_tx_data", 64'(o_tx_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2x2 [1,2;3,4] at 0x10 with ready held high.
    mem[8'h10] = 32'd1; mem[8'h11] = 32'd2; mem[8'h12] = 32'd3; mem[8'h13] = 32'd4;
    run_print(8'h10, 32'd2, 32'd2, "1 2\r\n3 4\r\n", 1'b0, 1'b0);
    cmp_text("t2x2", "1 2\r\n3 4\r\n");
    chk_run("t2x2", 0);

    // 1x3 [0,10,0xFFFFFFFF].
    mem[8'h20] = 32'd0; mem[8'h21] = 32'd10; mem[8'h22] = 32'hFFFF_FFFF;
`ifdef PRINT_SIGNED_EN
    s_exp = "0 10 -1\r\n";
`else
    s_exp = "0 10 4294967295\r\n";
`endif
    run_print(8'h20, 32'd1, 32'd3, s_exp, 1'b0, 1'b0);
    cmp_text("t1x3", s_exp);
    chk_run("t1x3", 0);

    // Illegal dimensions: done and err together, three cycles after start.
    i_m = 32'd6; i_n = 32'd2;
    @(negedge clk);
    i_start_print = 1'b1;
    @(negedge clk);
    i_start_print = 1'b0;
    chk("err_busy", 64'(o_busy), 64'd1);
    lat = 0; vseen = 0; errv = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      if (o_tx_valid === 1'b1) vseen++;
      if (o_print_done === 1'b1) begin
        lat = k;
        errv = (o_err === 1'b1) ? 1 : 0;
        break;
      end
    end
    chk("err_latency", 64'(lat), 64'd3);
    chk("err_flag", 64'(errv), 64'd1);
    chk("err_no_valid", 64'(vseen), 64'd0);
    // Zero columns and a too-wide matrix also flag an error with no output.
    run_print(8'h00, 32'd2, 32'd0, "", 1'b0, 1'b0);
    chk("err_n0_valid", 64'(vcount), 64'd0);
    chk_run("err_n0", 1);
    run_print(8'h00, 32'd5, 32'd7, "", 1'b0, 1'b0);
    chk("err_n7_valid", 64'(vcount), 64'd0);
    chk_run("err_n7", 1);

    // 5x5 with mixed random/corner values, first with ready high.
    for (int i = 0; i < 25; i++) mem[8'h40 + 8'(i)] = $urandom;
    mem[8'h40] = 32'd0;          mem[8'h41] = 32'hFFFF_FFFF; mem[8'h42] = 32'h8000_0000;
    mem[8'h43] = 32'd9;          mem[8'h44] = 32'd10;        mem[8'h45] = 32'd999_999_999;
    mem[8'h46] = 32'd1_000_000_000; mem[8'h47] = $urandom_range(0, 99);
    s_exp = exp_text(8'h40, 5, 5);
    run_print(8'h40, 32'd5, 32'd5, s_exp, 1'b0, 1'b0);
    cmp_text("t5x5", s_exp);
    chk_run("t5x5", 0);
    ref_q = got_q;
    // Same matrix with random backpressure must produce identical bytes.
    run_print(8'h40, 32'd5, 32'd5, s_exp, 1'b1, 1'b0);
    cmp_text("t5x5_bp", s_exp);
    chk_run("t5x5_bp", 0);
    chk("t5x5_bp_same", 64'(got_q == ref_q), 64'd1);
    chk("t5x5_bp_stalled", 64'(stalls > 0), 64'd1);

    // Address wrap: 3x3 at 0xF8 crosses 0xFF.
    for (int i = 0; i < 9; i++) mem[8'hF8 + 8'(i)] = $urandom_range(0, 100000);
    s_exp = exp_text(8'hF8, 3, 3);
    run_print(8'hF8, 32'd3, 32'd3, s_exp, 1'b0, 1'b0);
    cmp_text("twrap", s_exp);
    chk_run("twrap", 0);

    // Reset while a digit is being offered, then a full reprint.
    for (int i = 0; i < 9; i++) mem[8'h80 + 8'(i)] = $urandom;
    i_base_addr = 8'h80; i_m = 32'd3; i_n = 32'd3; i_tx_ready = 1'b0;
    @(negedge clk);
    i_start_print = 1'b1;
    @(negedge clk);
    i_start_print = 1'b0;
    waited = 0;
    while (o_tx_valid !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    chk("rst_mid_reached_emit", 64'(o_tx_valid), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(o_tx_valid), 64'd0);
    chk("rst_mid_data", 64'(o_tx_data), 64'd0);
    chk("rst_mid_busy", 64'(o_busy), 64'd0);
    chk("rst_mid_rd_addr", 64'(o_rd_addr), 64'd0);
    chk("rst_mid_done_err", 64'({o_print_done, o_err}), 64'd0);
    i_tx_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    s_exp = exp_text(8'h80, 3, 3);
    run_print(8'h80, 32'd3, 32'd3, s_exp, 1'b0, 1'b0);
    cmp_text("trst", s_exp);
    chk_run("trst", 0);

    // Start pulsed mid-print is ignored.
    for (int i = 0; i < 6; i++) mem[8'hA0 + 8'(i)] = $urandom_range(0, 5000);
    s_exp = exp_text(8'hA0, 2, 3);
    run_print(8'hA0, 32'd2, 32'd3, s_exp, 1'b1, 1'b1);
    cmp_text("trestart", s_exp);
    chk_run("trestart", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
